// File: rtl/kbd_pkg.sv
// Shared constants, state encoding and helpers for the keyboard receive stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package kbd_pkg;

    // PS/2 Set 2 prefix and modifier codes
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    // ASCII control characters produced by the translator
    localparam logic [7:0] ASC_NUL   = 8'h00;
    localparam logic [7:0] ASC_BS    = 8'h08;
    localparam logic [7:0] ASC_TAB   = 8'h09;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_ESC   = 8'h1B;
    localparam logic [7:0] ASC_SPACE = 8'h20;

    // Prefix tracker states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } kbd_state_t;

    function automatic logic is_shift_code(input logic [7:0] code);
        return (code == SC_LSHIFT) || (code == SC_RSHIFT);
    endfunction

endpackage

// File: rtl/kbd_set2_ascii.sv
// Set 2 make code to ASCII lookup (US layout); KBD_SHIFT_EN adds the shifted table.
// Latency: purely combinational.
// Backpressure: none; unmapped codes report mapped=0 and ascii=0x00.
module kbd_set2_ascii (
    input  logic [7:0] code,
    input  logic       shift,
    output logic [7:0] ascii,
    output logic       mapped
);
    import kbd_pkg::*;

    logic [7:0] lo;

    // Unshifted character for each supported make code
    always_comb begin
        lo     = ASC_NUL;
        mapped = 1'b1;
        case (code)
            8'h1C: lo = "a";  8'h32: lo = "b";  8'h21: lo = "c";  8'h23: lo = "d";
            8'h24: lo = "e";  8'h2B: lo = "f";  8'h34: lo = "g";  8'h33: lo = "h";
            8'h43: lo = "i";  8'h3B: lo = "j";  8'h42: lo = "k";  8'h4B: lo = "l";
            8'h3A: lo = "m";  8'h31: lo = "n";  8'h44: lo = "o";  8'h4D: lo = "p";
            8'h15: lo = "q";  8'h2D: lo = "r";  8'h1B: lo = "s";  8'h2C: lo = "t";
            8'h3C: lo = "u";  8'h2A: lo = "v";  8'h1D: lo = "w";  8'h22: lo = "x";
            8'h35: lo = "y";  8'h1A: lo = "z";
            8'h45: lo = "0";  8'h16: lo = "1";  8'h1E: lo = "2";  8'h26: lo = "3";
            8'h25: lo = "4";  8'h2E: lo = "5";  8'h36: lo = "6";  8'h3D: lo = "7";
            8'h3E: lo = "8";  8'h46: lo = "9";
            8'h4E: lo = "-";  8'h55: lo = "=";  8'h41: lo = ",";  8'h49: lo = ".";
            8'h4A: lo = "/";
            8'h29: lo = ASC_SPACE;
            8'h5A: lo = ASC_CR;
            8'h66: lo = ASC_BS;
            8'h0D: lo = ASC_TAB;
            8'h76: lo = ASC_ESC;
            default: mapped = 1'b0;
        endcase
    end

`ifdef KBD_SHIFT_EN
    logic [7:0] hi;

    // Shifted variant derived from the unshifted character; controls pass through
    always_comb begin
        hi = lo;
        if (lo >= "a" && lo <= "z") begin
            hi = lo - 8'h20;
        end else begin
            case (lo)
                "0": hi = ")";  "1": hi = "!";  "2": hi = "@";  "3": hi = "#";
                "4": hi = "$";  "5": hi = "%";  "6": hi = "^";  "7": hi = "&";
                "8": hi = "*";  "9": hi = "(";
                "-": hi = "_";  "=": hi = "+";  ",": hi = "<";  ".": hi = ">";
                "/": hi = "?";
                default: hi = lo;
            endcase
        end
    end

    assign ascii = shift ? hi : lo;
`else
    logic unused_shift;
    assign unused_shift = shift;
    assign ascii        = lo;
`endif

endmodule

// File: rtl/kbd_scancode_queue.sv
// PS/2 Set 2 byte stream -> ASCII FWFT queue; optional shift support via KBD_SHIFT_EN.
// Latency: strobe edge sampled at N -> byte reg N+2 -> push N+3; pop updates head next cycle.
// Backpressure: none upstream; push into a full queue drops the char and sets sticky overflow.
module kbd_scancode_queue #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               scan_code,
    input  logic                     scan_strobe,
    input  logic                     key_pop,
    input  logic                     ovf_clr,
    output logic [7:0]               key_ascii,
    output logic                     key_valid,
    output logic [$clog2(DEPTH):0]   key_count,
    output logic                     overflow
);
    import kbd_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic strobe_s1, strobe_s2, strobe_s3;
    logic strobe_rise;
    logic [7:0] byte_dat;
    logic byte_vld;

    kbd_state_t state, state_next;
    logic push;
    logic shift;
    logic [7:0] xl_ascii;
    logic xl_mapped;

    logic [7:0] mem [DEPTH];
    logic [CW-1:0] wptr, rptr;
    logic full, do_pop, do_push, ovf_set;

    // Synchronise the strobe and keep one history flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_s1 <= 1'b0;
            strobe_s2 <= 1'b0;
            strobe_s3 <= 1'b0;
        end else begin
            strobe_s1 <= scan_strobe;
            strobe_s2 <= strobe_s1;
            strobe_s3 <= strobe_s2;
        end
    end

    assign strobe_rise = strobe_s2 & ~strobe_s3;

    // Capture one byte per strobe rising edge; byte_vld is a one-cycle marker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_dat <= 8'h00;
            byte_vld <= 1'b0;
        end else begin
            byte_vld <= strobe_rise;
            if (strobe_rise) begin
                byte_dat <= scan_code;
            end
        end
    end

    kbd_set2_ascii u_xlat (
        .code   (byte_dat),
        .shift  (shift),
        .ascii  (xl_ascii),
        .mapped (xl_mapped)
    );

    // Prefix state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Prefix tracking; only a plain make code in IDLE can produce a character
    always_comb begin
        state_next = state;
        push       = 1'b0;
        if (byte_vld) begin
            case (state)
                ST_IDLE: begin
                    if (byte_dat == SC_BREAK) begin
                        state_next = ST_BRK;
                    end else if (byte_dat == SC_EXT) begin
                        state_next = ST_EXT;
                    end else begin
                        push = xl_mapped;
                    end
                end
                ST_BRK:     state_next = ST_IDLE;
                ST_EXT:     state_next = (byte_dat == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                ST_EXT_BRK: state_next = ST_IDLE;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

`ifdef KBD_SHIFT_EN
    // Shift follows make in IDLE and break (BRK state) of either shift key
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift <= 1'b0;
        end else if (byte_vld && is_shift_code(byte_dat)) begin
            if (state == ST_IDLE) begin
                shift <= 1'b1;
            end else if (state == ST_BRK) begin
                shift <= 1'b0;
            end
        end
    end
`else
    assign shift = 1'b0;
`endif

    assign key_count = wptr - rptr;
    assign key_valid = (key_count != '0);
    assign full      = (key_count == CW'(DEPTH));
    assign do_pop    = key_pop & key_valid;
    // A pop in the same cycle frees the slot, so a full queue can still accept
    assign do_push   = push & (~full | do_pop);
    assign ovf_set   = push & full & ~do_pop;

    // Storage array; no reset needed since the pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= xl_ascii;
        end
    end

    // Queue pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Sticky overflow; a new drop takes priority over a clear in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    assign key_ascii = key_valid ? mem[rptr[AW-1:0]] : ASC_NUL;

endmodule

// File: tb/tb_kbd_scancode_queue.sv
// Directed bench for kbd_scancode_queue (expectations follow KBD_SHIFT_EN when defined).
// Latency: drives at #1 after posedge, samples at #1 after posedge.
// Backpressure: exercised through full-queue overflow and push+pop at full.
module tb_kbd_scancode_queue;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

`ifdef KBD_SHIFT_EN
    localparam logic [7:0] EXP_SHIFT_A = 8'h41;
    localparam logic [7:0] EXP_SHIFT_1 = 8'h21;
`else
    localparam logic [7:0] EXP_SHIFT_A = 8'h61;
    localparam logic [7:0] EXP_SHIFT_1 = 8'h31;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    scan_code;
    logic          scan_strobe;
    logic          key_pop;
    logic          ovf_clr;
    logic [7:0]    key_ascii;
    logic          key_valid;
    logic [CW-1:0] key_count;
    logic          overflow;

    int errors = 0;
    int checks = 0;

    logic [7:0] codes [17];
    logic [7:0] exp_chr;

    kbd_scancode_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .scan_code   (scan_code),
        .scan_strobe (scan_strobe),
        .key_pop     (key_pop),
        .ovf_clr     (ovf_clr),
        .key_ascii   (key_ascii),
        .key_valid   (key_valid),
        .key_count   (key_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        scan_code   = b;
        scan_strobe = 1'b1;
        repeat (4) tick();
        scan_strobe = 1'b0;
        repeat (4) tick();
    endtask

    task automatic pop_one();
        key_pop = 1'b1;
        tick();
        key_pop = 1'b0;
    endtask

    initial begin
        codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                  8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15};
        rst = 1'b1; scan_code = 8'h00; scan_strobe = 1'b0; key_pop = 1'b0; ovf_clr = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_count", 32'(key_count), 32'h0);
        check("rst_ascii", 32'(key_ascii), 32'h00);
        check("rst_ovf",   32'(overflow),  32'h0);
        rst = 1'b0;
        tick();

        // Latency of a single make code, strobe held high yields one byte
        scan_code = 8'h1C; scan_strobe = 1'b1;
        repeat (3) tick();
        check("lat_early_valid", 32'(key_valid), 32'h0);
        tick();
        check("lat_valid", 32'(key_valid), 32'h1);
        check("lat_ascii", 32'(key_ascii), 32'h61);
        check("lat_count", 32'(key_count), 32'h1);
        repeat (3) tick();
        scan_strobe = 1'b0;
        repeat (4) tick();
        check("held_count", 32'(key_count), 32'h1);
        pop_one();
        check("pop_valid", 32'(key_valid), 32'h0);
        check("pop_ascii", 32'(key_ascii), 32'h00);

        // Shift make / letter / letter break / shift break / letter
        send_byte(8'h12); send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h12); send_byte(8'h1C);
        check("shift_count", 32'(key_count), 32'h2);
        check("shift_first", 32'(key_ascii), 32'(EXP_SHIFT_A));
        pop_one();
        check("shift_second", 32'(key_ascii), 32'h61);
        pop_one();
        check("shift_empty", 32'(key_count), 32'h0);

        // Extended make/break is swallowed; following plain key is queued
        send_byte(8'hE0); send_byte(8'h75); send_byte(8'hE0); send_byte(8'hF0);
        send_byte(8'h75); send_byte(8'h16);
        check("ext_count", 32'(key_count), 32'h1);
        check("ext_ascii", 32'(key_ascii), 32'h31);
        pop_one();
        send_byte(8'h59); send_byte(8'h16);
        check("shift_digit", 32'(key_ascii), 32'(EXP_SHIFT_1));
        pop_one();
        send_byte(8'hF0); send_byte(8'h59);
        check("shift_rel_count", 32'(key_count), 32'h0);

        // Pop while empty is ignored
        pop_one();
        check("empty_pop_count", 32'(key_count), 32'h0);
        check("empty_pop_ascii", 32'(key_ascii), 32'h00);

        // Fill to DEPTH, then one more overflows
        for (int i = 0; i < 17; i++) begin
            send_byte(codes[i]);
            if (i == DEPTH - 1) begin
                check("full_count", 32'(key_count), 32'(DEPTH));
                check("full_ovf",   32'(overflow),  32'h0);
            end
        end
        check("ovf_count", 32'(key_count), 32'(DEPTH));
        check("ovf_set",   32'(overflow),  32'h1);
        check("ovf_head",  32'(key_ascii), 32'h61);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'h0);

        // Push 'r' and pop 'a' on the same edge while full
        scan_code = 8'h2D; scan_strobe = 1'b1;
        repeat (3) tick();
        key_pop = 1'b1;
        tick();
        key_pop = 1'b0;
        check("pp_count", 32'(key_count), 32'(DEPTH));
        check("pp_ovf",   32'(overflow),  32'h0);
        tick();
        scan_strobe = 1'b0;
        repeat (4) tick();

        // Drain: b..p then r
        for (int i = 0; i < DEPTH - 1; i++) begin
            exp_chr = 8'h62 + 8'(i);
            check("drain", 32'(key_ascii), 32'(exp_chr));
            pop_one();
        end
        check("drain_tail", 32'(key_ascii), 32'h72);
        pop_one();
        check("drain_empty", 32'(key_valid), 32'h0);

        // Reset mid-sequence discards break state and shift
        send_byte(8'h12); send_byte(8'hF0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        send_byte(8'h1C);
        check("rst_mid_count", 32'(key_count), 32'h1);
        check("rst_mid_ascii", 32'(key_ascii), 32'h61);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kbd_scancode_queue.md
# kbd_scancode_queue

Keyboard receive stage between `ps2_keyboard` and its consumers (CPU I/O port, console writer). Takes the raw PS/2 Set 2 byte stream (`decoded_key` plus `read_key` strobe), tracks break/extended prefixes and shift state, translates make codes to ASCII, and buffers characters in a first-word-fall-through FIFO with a valid/pop handshake. Replaces the current practice of clocking logic directly off `read_key`; everything here runs on `global_clk`.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, 2..256
- `clk`  in  1  global 50 MHz clock (`global_clk`)
- `rst`  in  1  reset, asynchronous, active-high
- `scan_code`  in  8  byte from `ps2_keyboard` (`decoded_key`)
- `scan_strobe`  in  1  `read_key`; each low-to-high transition marks one new byte
- `key_pop`  in  1  consumer takes head entry when `key_valid` is high
- `ovf_clr`  in  1  clears `overflow`
- `key_ascii`  out  8  FIFO head character; 0x00 when empty
- `key_valid`  out  1  FIFO not empty
- `key_count`  out  $clog2(DEPTH)+1  entries held, 0..DEPTH
- `overflow`  out  1  sticky: a character was dropped because FIFO was full

## Operation
- Input capture: `scan_strobe` registered through 2 flops (sync) plus 1 history flop; rising edge -> `scan_code` latched into byte register, one byte per edge. Strobe held high produces no further bytes.
- Prefix FSM, states IDLE, BRK, EXT, EXT_BRK:
  - IDLE: 0xF0 -> BRK; 0xE0 -> EXT; 0x12/0x59 -> set shift; other byte -> translate, push if mapped.
  - BRK: 0x12/0x59 -> clear shift; any byte -> IDLE, nothing pushed.
  - EXT: 0xF0 -> EXT_BRK; any other byte -> IDLE, nothing pushed (extended keys unsupported).
  - EXT_BRK: any byte -> IDLE, nothing pushed.
  - 0xE0/0xF0 received in BRK, EXT_BRK are consumed as the terminating byte (no nesting).
- Translation (combinational, US layout, Set 2): a-z, 0-9, space 0x29->0x20, enter 0x5A->0x0D, backspace 0x66->0x08, tab 0x0D->0x09, escape 0x76->0x1B, `-` 0x4E, `=` 0x55, `,` 0x41, `.` 0x49, `/` 0x4A. Unmapped codes (incl. 0xAA, 0xFA, 0xE1) are dropped.
- FIFO: DEPTH x 8 register array, read/write pointers one bit wider than address; `key_count` = wptr - rptr. Head shown combinationally from array at rptr.
- Pop with `key_valid` low ignored. Push when full and no pop in same cycle: character dropped, `overflow` set. Push and pop in same cycle while full: both performed, count unchanged, no overflow.
- `ovf_clr` and a new overflow in same cycle: overflow wins (stays set).

## Timing
- Reset: FSM IDLE, shift 0, pointers 0; `key_valid`=0, `key_count`=0, `overflow`=0, `key_ascii`=0x00. Asserting `rst` mid-sequence discards partial prefix state, shift and all buffered characters.
- Latency: rising edge of `scan_strobe` sampled at edge N -> byte register at N+2 -> push at N+3 -> `key_valid`/`key_ascii` visible after N+3 if FIFO was empty.
- Pop: `key_valid && key_pop` at edge M -> next entry (or empty) presented after M; back-to-back pops every cycle allowed.
- Minimum strobe spacing: 3 clk cycles high/low each (PS/2 bytes arrive ~1 ms apart, margin is huge).

## Configuration
- `KBD_SHIFT_EN` defined: shift tracked; shifted letters map uppercase, shifted digits to `)!@#$%^&*(`, shifted punctuation to `_+<>?`.
- Undefined: shift make/break codes are consumed and ignored; only unshifted characters produced; shift register and shifted table not synthesised.

## Structure
- Shared package `kbd_pkg`: scan-code constants (`SC_BREAK`=0xF0, `SC_EXT`=0xE0, `SC_LSHIFT`=0x12, `SC_RSHIFT`=0x59), FSM state enum, ASCII control constants.
- One sub-module: `kbd_set2_ascii` — combinational lookup (`code`, `shift` -> `ascii`, `mapped`). FIFO stays inline.

## Test plan
- Reset then strobe 0x1C -> after 3 cycles `key_valid`=1, `key_ascii`=0x61, `key_count`=1; pop -> `key_valid`=0, `key_ascii`=0x00.
- Sequence 0x12, 0x1C, 0xF0, 0x1C, 0xF0, 0x12, 0x1C -> FIFO holds 0x41 then 0x61 (0x61 0x61 without `KBD_SHIFT_EN`).
- 0xE0, 0x75, 0xE0, 0xF0, 0x75, then 0x16 -> only 0x31 queued; with shift held, 0x16 -> 0x21.
- Push DEPTH+1 mapped keys without popping -> `key_count`=DEPTH, `overflow`=1, first DEPTH characters intact; `ovf_clr` -> `overflow`=0.
- FIFO full, push and pop same cycle -> count stays DEPTH, no overflow, new char at tail.
- Assert `rst` after 0xF0 received, then 0x1C -> 0x61 queued (break state discarded).
